// File: rtl/iomem_pkg.sv
// iomem_pkg
// Shared constants and types for the 128-bit iomem initiator.
//   BLOCK_SIZE  : cache line / bus data width in bits
//   NUMS_BYTE   : byte strobes per line
//   BYTE_OFFSET : address bits covered by one line
//   iomem_state_e : transaction sequencer states
//   iomem_src_e   : requester identity (I-cache or D-cache)
package iomem_pkg;

  localparam int BLOCK_SIZE  = 128;
  localparam int NUMS_BYTE   = BLOCK_SIZE / 8;
  localparam int BYTE_OFFSET = $clog2(NUMS_BYTE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } iomem_state_e;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } iomem_src_e;

endpackage

// File: rtl/iomem_rr_arb.sv
// iomem_rr_arb
// Two-way round-robin arbiter between the I-cache (bit 0) and D-cache (bit 1).
// A lone requester is always granted; on a tie the side that did not win last
// time is granted. The last-grant record moves only when advance_i is high and
// something is granted.
// Ports:
//   clk_o     in  clock
//   rst_n     in  synchronous active-low reset (last grant -> D-cache)
//   req_i     in  [1:0] request vector {dc, ic}
//   advance_i in  commit the current grant into the last-grant record
//   gnt_o     out [1:0] one-hot (or zero) grant, combinational from req_i
module iomem_rr_arb
  import iomem_pkg::*;
(
  input  logic       clk_o,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  iomem_src_e last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Tie: favour whichever side was not served last.
      2'b11:   gnt_o = (last_q == REQ_DC) ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (gnt_o != 2'b00)) begin
      last_d = gnt_o[1] ? REQ_DC : REQ_IC;
    end
  end

  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      last_q <= REQ_DC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/iomem_master.sv
// iomem_master
// Initiator side of the 128-bit iomem bus. Merges I-cache line fills and
// D-cache fills/writebacks/MMIO into single bus transactions, one at a time.
// Sequence per transaction: IDLE (grant) -> REQ (iomem_valid high until
// iomem_ready) -> GAP (valid low, response pulse) -> IDLE.
//
// Optional feature macro: IOMEM_TIMEOUT_EN
//   When defined, a 16-bit wait counter aborts a REQ phase after TIMEOUT_CYC
//   cycles without ready; the response pulse then carries rsp_err_o=1 and
//   zero data. When undefined, REQ waits forever and rsp_err_o is tied 0.
//
// Parameters: ADDR_W (address width), TIMEOUT_CYC (only with the macro).
// Line width is fixed by iomem_pkg::BLOCK_SIZE.
//
// Ports:
//   clk_o, rst_n                  clock, synchronous active-low reset
//   ic_req_valid/ready/addr       I-cache fill request (addr low bits cleared)
//   ic_rsp_valid/data             I-cache response pulse and line
//   dc_req_valid/ready/addr/wdata/wstrb  D-side request (wstrb==0 -> read)
//   dc_rsp_valid/data             D-side response pulse (data valid for reads)
//   rsp_err_o                     qualifies a response pulse as a timeout abort
//   iomem_valid/ready/addr/wstrb/wdata/rdata  bus handshake and fields
//   busy_o                        high whenever a transaction is in progress
module iomem_master
  import iomem_pkg::*;
#(
  parameter int ADDR_W = 32
`ifdef IOMEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic                  clk_o,
  input  logic                  rst_n,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_W-1:0]     ic_req_addr,
  output logic                  ic_rsp_valid,
  output logic [BLOCK_SIZE-1:0] ic_rsp_data,
  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic [ADDR_W-1:0]     dc_req_addr,
  input  logic [BLOCK_SIZE-1:0] dc_req_wdata,
  input  logic [NUMS_BYTE-1:0]  dc_req_wstrb,
  output logic                  dc_rsp_valid,
  output logic [BLOCK_SIZE-1:0] dc_rsp_data,
  output logic                  rsp_err_o,
  output logic                  iomem_valid,
  input  logic                  iomem_ready,
  output logic [ADDR_W-1:0]     iomem_addr,
  output logic [NUMS_BYTE-1:0]  iomem_wstrb,
  output logic [BLOCK_SIZE-1:0] iomem_wdata,
  input  logic [BLOCK_SIZE-1:0] iomem_rdata,
  output logic                  busy_o
);

  // I-cache fills are always line aligned on the bus.
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(NUMS_BYTE - 1);

  iomem_state_e          state_q, state_d;
  iomem_src_e            owner_q, owner_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [NUMS_BYTE-1:0]  wstrb_q, wstrb_d;
  logic [BLOCK_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                  ic_rsp_q, ic_rsp_d;
  logic                  dc_rsp_q, dc_rsp_d;

`ifdef IOMEM_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`endif

  logic [1:0] arb_req;
  logic [1:0] gnt;

  // Grants are only offered in IDLE, so requests during REQ/GAP see ready=0.
  assign arb_req = {dc_req_valid, ic_req_valid} & {2{state_q == IDLE}};

  iomem_rr_arb u_arb (
    .clk_o     (clk_o),
    .rst_n     (rst_n),
    .req_i     (arb_req),
    .advance_i (state_q == IDLE),
    .gnt_o     (gnt)
  );

  assign ic_req_ready = gnt[0];
  assign dc_req_ready = gnt[1];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rsp_data_d = rsp_data_q;
    ic_rsp_d   = 1'b0;
    dc_rsp_d   = 1'b0;
`ifdef IOMEM_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          owner_d = REQ_IC;
          addr_d  = ic_req_addr & ~LINE_MASK;
          wdata_d = '0;
          wstrb_d = '0;
          state_d = REQ;
`ifdef IOMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (gnt[1]) begin
          owner_d = REQ_DC;
          addr_d  = dc_req_addr;
          wdata_d = dc_req_wdata;
          wstrb_d = dc_req_wstrb;
          state_d = REQ;
`ifdef IOMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        // A ready in the final watchdog cycle still counts as a completion.
        if (iomem_ready) begin
          rsp_data_d = iomem_rdata;
          ic_rsp_d   = (owner_q == REQ_IC);
          dc_rsp_d   = (owner_q == REQ_DC);
          state_d    = GAP;
        end
`ifdef IOMEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          err_d      = 1'b1;
          ic_rsp_d   = (owner_q == REQ_IC);
          dc_rsp_d   = (owner_q == REQ_DC);
          state_d    = GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      // One dead cycle with valid low: the responder starts a RAM access on
      // valid & !ready, so valid must not stay high into the next request.
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_o) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= REQ_IC;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rsp_data_q <= '0;
      ic_rsp_q   <= 1'b0;
      dc_rsp_q   <= 1'b0;
`ifdef IOMEM_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rsp_data_q <= rsp_data_d;
      ic_rsp_q   <= ic_rsp_d;
      dc_rsp_q   <= dc_rsp_d;
`ifdef IOMEM_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign iomem_valid  = (state_q == REQ);
  assign iomem_addr   = addr_q;
  assign iomem_wdata  = wdata_q;
  assign iomem_wstrb  = wstrb_q;
  assign ic_rsp_valid = ic_rsp_q;
  assign dc_rsp_valid = dc_rsp_q;
  assign ic_rsp_data  = rsp_data_q;
  assign dc_rsp_data  = rsp_data_q;
  assign busy_o       = (state_q != IDLE);

`ifdef IOMEM_TIMEOUT_EN
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule
